// File: rtl/wave_osc.sv
// -----------------------------------------------------------------------------
// wave_osc -- run-time tunable audio oscillator.
//
// A phase accumulator (DDS) feeds a waveform generator: triangle, sawtooth,
// square or variable-duty pulse. The result goes into a one-entry registered
// output stage with a valid/ready handshake. Frequency, shape and duty are
// sampled on every accepted sample, so they can change from one sample to the
// next.
//
// Parameters:
//   width_p        output sample width (signed two's complement)
//   phase_width_p  phase accumulator width P; needs P >= width_p + 1, P >= 8
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset (phase, valid, data -> 0)
//   phase_inc_i  unsigned phase increment per sample (f = inc * fs / 2^P)
//   mode_i       0 triangle, 1 sawtooth, 2 square, 3 pulse
//   duty_i       pulse high time in 1/256 of the period (pulse mode only)
//   sync_i       hard sync: restart the phase at 0
//   ready_i      downstream accepts the current sample
//   valid_o      data_o holds a sample
//   data_o       signed output sample
// -----------------------------------------------------------------------------
module wave_osc #(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [phase_width_p-1:0]   phase_inc_i,
  input  logic [1:0]                 mode_i,
  input  logic [7:0]                 duty_i,
  input  logic                       sync_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic signed [width_p-1:0]  data_o
);

  localparam int W = width_p;
  localparam int P = phase_width_p;

  // Full-scale levels for square/pulse: +A and -A, A = 2^(W-1)-1.
  localparam logic [W-1:0] amp_pos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] amp_neg = {1'b1, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_PULSE  = 2'd3
  } mode_e;

  logic [P-1:0] phase_reg, phase_next;
  logic [W-1:0] data_reg, data_next;
  logic         valid_reg, valid_next;

  logic         load;
  logic [P-1:0] phase_src;
  logic         phase_msb;
  logic [W-1:0] saw_t;
  logic [W-1:0] tri_u;
  logic [W-1:0] tri_v;
  logic [7:0]   pulse_pos;
  logic [W-1:0] wave;

  // The output slot is refilled whenever it is empty or being consumed.
  assign load = ~valid_reg | ready_i;

  // Hard sync makes the sample taken at this edge come from phase 0.
  assign phase_src = sync_i ? '0 : phase_reg;

  assign phase_msb = phase_src[P-1];
  assign saw_t     = phase_src[P-1 -: W];
  assign tri_u     = phase_src[P-2 -: W];
  assign pulse_pos = phase_src[P-1 -: 8];

  // Triangle: fold the ramp back down during the second half period.
  for (genvar gi = 0; gi < W; gi++) begin : g_tri_fold
    assign tri_v[gi] = tri_u[gi] ^ phase_msb;
  end

  // Inverting the MSB turns an offset-binary ramp into two's complement.
  always_comb begin
    wave = '0;
    case (mode_e'(mode_i))
      MODE_TRI:    wave = {~tri_v[W-1], tri_v[W-2:0]};
      MODE_SAW:    wave = {~saw_t[W-1], saw_t[W-2:0]};
      MODE_SQUARE: wave = phase_msb ? amp_neg : amp_pos;
      MODE_PULSE:  wave = (pulse_pos < duty_i) ? amp_pos : amp_neg;
      default:     wave = '0;
    endcase
  end

  always_comb begin
    phase_next = phase_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    if (load) begin
      data_next  = wave;
      phase_next = phase_src + phase_inc_i;
      valid_next = 1'b1;
    end else if (sync_i) begin
      // Sample is held; only the phase restarts.
      phase_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign valid_o = valid_reg;
  assign data_o  = data_reg;

endmodule

// File: tb/tb_wave_osc.sv
// -----------------------------------------------------------------------------
// tb_wave_osc -- self-checking bench for wave_osc (width 12, phase 24 bits,
// increment 262144 = 64 samples per period). A table of {mode, duty, sample
// index, expected value} records covers the waveforms; hand-written sequences
// cover backpressure, hard sync, mode change under backpressure and reset.
// -----------------------------------------------------------------------------
module tb_wave_osc;

  localparam int W   = 12;
  localparam int P   = 24;
  localparam int INC = 262144;
  localparam int NV  = 21;

  logic                clk;
  logic                reset_i;
  logic [P-1:0]        phase_inc_i;
  logic [1:0]          mode_i;
  logic [7:0]          duty_i;
  logic                sync_i;
  logic                ready_i;
  logic                valid_o;
  logic signed [W-1:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] duty;
    int         k;
    int         expv;
  } vec_t;

  vec_t vecs[NV];
  int   samples[0:64];

  wave_osc #(.width_p(W), .phase_width_p(P)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .phase_inc_i (phase_inc_i),
    .mode_i      (mode_i),
    .duty_i      (duty_i),
    .sync_i      (sync_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .data_o      (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected to end well before 500000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reset, then stream 65 samples with ready held high and record them.
  task automatic run_stream(input logic [1:0] m, input logic [7:0] d);
    reset_i     = 1'b1;
    ready_i     = 1'b1;
    sync_i      = 1'b0;
    mode_i      = m;
    duty_i      = d;
    phase_inc_i = P'(INC);
    step();
    step();
    check("reset valid", int'(valid_o), 0);
    check("reset data", int'(data_o), 0);
    reset_i = 1'b0;
    for (int i = 0; i <= 64; i++) begin
      step();
      samples[i] = valid_o ? int'(data_o) : 99999;
    end
  endtask

  initial begin
    logic [1:0] last_mode;
    logic [7:0] last_duty;
    bit         have_run;

    reset_i     = 1'b1;
    phase_inc_i = P'(INC);
    mode_i      = 2'd0;
    duty_i      = 8'd0;
    sync_i      = 1'b0;
    ready_i     = 1'b1;

    vecs = '{
      '{2'd0, 8'd0,   0, -2048}, '{2'd0, 8'd0,  16,     0},
      '{2'd0, 8'd0,  31,  1920}, '{2'd0, 8'd0,  32,  2047},
      '{2'd0, 8'd0,  33,  1919}, '{2'd0, 8'd0,  63, -1921},
      '{2'd0, 8'd0,  64, -2048},
      '{2'd1, 8'd0,   0, -2048}, '{2'd1, 8'd0,  32,     0},
      '{2'd1, 8'd0,  63,  1984}, '{2'd1, 8'd0,  64, -2048},
      '{2'd2, 8'd0,   0,  2047}, '{2'd2, 8'd0,  31,  2047},
      '{2'd2, 8'd0,  32, -2047}, '{2'd2, 8'd0,  63, -2047},
      '{2'd3, 8'd64,  0,  2047}, '{2'd3, 8'd64, 15,  2047},
      '{2'd3, 8'd64, 16, -2047}, '{2'd3, 8'd64, 63, -2047},
      '{2'd3, 8'd0,   0, -2047}, '{2'd3, 8'd0,  40, -2047}
    };

    // ---------------- table-driven waveform vectors ----------------
    have_run  = 1'b0;
    last_mode = 2'd0;
    last_duty = 8'd0;
    for (int v = 0; v < NV; v++) begin
      if (!have_run || vecs[v].mode != last_mode || vecs[v].duty != last_duty) begin
        run_stream(vecs[v].mode, vecs[v].duty);
        have_run  = 1'b1;
        last_mode = vecs[v].mode;
        last_duty = vecs[v].duty;
      end
      check($sformatf("mode%0d duty%0d k%0d", vecs[v].mode, vecs[v].duty, vecs[v].k),
            samples[vecs[v].k], vecs[v].expv);
    end

    // ---------------- backpressure on sawtooth ----------------
    reset_i     = 1'b1;
    mode_i      = 2'd1;
    duty_i      = 8'd0;
    phase_inc_i = P'(INC);
    ready_i     = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    step();                                // k = 0 visible
    check("first sample latency valid", int'(valid_o), 1);
    check("first sample k0", int'(data_o), -2048);
    for (int i = 0; i < 10; i++) step();   // k = 10 visible
    check("bp k10", int'(data_o), -1408);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp hold%0d data", i), int'(data_o), -1408);
      check($sformatf("bp hold%0d valid", i), int'(valid_o), 1);
    end
    ready_i = 1'b1;
    step();
    check("bp resume k11", int'(data_o), -1344);
    step();
    check("bp resume k12", int'(data_o), -1280);

    // ---------------- hard sync at load of k=20 ----------------
    for (int i = 0; i < 7; i++) step();    // k = 19 visible
    check("pre-sync k19", int'(data_o), -832);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check("sync sample wave(0)", int'(data_o), -2048);
    step();
    check("sync next wave(inc)", int'(data_o), -1984);
    step();
    check("sync wave(2inc)", int'(data_o), -1920);

    // ---------------- mode change while stalled ----------------
    ready_i = 1'b0;
    mode_i  = 2'd2;
    step();
    check("mode stall hold a", int'(data_o), -1920);
    step();
    check("mode stall hold b", int'(data_o), -1920);
    ready_i = 1'b1;
    step();
    check("mode new square k3", int'(data_o), 2047);

    // ---------------- sync without load ----------------
    mode_i  = 2'd1;
    step();                                // saw k = 4 visible
    check("saw k4", int'(data_o), -1792);
    ready_i = 1'b0;
    step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check("stall sync hold", int'(data_o), -1792);
    ready_i = 1'b1;
    step();
    check("stall sync restart wave(0)", int'(data_o), -2048);
    step();
    check("stall sync wave(inc)", int'(data_o), -1984);

    // ---------------- reset mid-stream, then zero increment ----------------
    for (int i = 0; i < 5; i++) step();
    reset_i = 1'b1;
    step();
    check("mid reset valid", int'(valid_o), 0);
    check("mid reset data", int'(data_o), 0);
    reset_i     = 1'b0;
    phase_inc_i = '0;
    step();
    check("post reset valid", int'(valid_o), 1);
    check("post reset first", int'(data_o), -2048);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("inc0 const%0d", i), int'(data_o), -2048);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_osc.md
# wave_osc

Parametrised, run-time-tunable audio oscillator: a phase accumulator (DDS) drives a selectable waveform generator (triangle, sawtooth, square, variable-duty pulse) into a one-entry registered output with a valid/ready stream. Successor to the fixed-frequency, ROM-based triangle source. Frequency, shape and duty change per sample without re-synthesis. Sits at the head of the synth datapath, feeding mixer/DAC stages at the sample rate set by downstream `ready_i`.

## Interface
- `width_p`, 12: output sample width, signed two's complement.
- `phase_width_p`, 24: phase accumulator width P. Must satisfy P >= width_p + 1 and P >= 8.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  reset, synchronous, active-high.
- `phase_inc_i`  in  phase_width_p  per-sample phase increment, unsigned. f_out = inc * f_s / 2^P.
- `mode_i`  in  2  0 triangle, 1 sawtooth, 2 square, 3 pulse.
- `duty_i`  in  8  pulse high-time in 1/256 of period (mode 3 only).
- `sync_i`  in  1  hard sync: restart phase at 0.
- `ready_i`  in  1  downstream accepts the sample.
- `valid_o`  out  1  `data_o` holds a sample.
- `data_o`  out  width_p  signed sample.

## Operation
- State: phase register p (P bits), output register, `valid_o` flag.
- Load event: edge where `valid_o`=0, or `valid_o`=1 and `ready_i`=1. At a load: output register <= wave(p, `mode_i`, `duty_i`); p <= p + `phase_inc_i` mod 2^P; `valid_o` <= 1.
- No load (`valid_o`=1, `ready_i`=0): output register, `valid_o`, p hold. Inputs ignored except `sync_i`.
- `sync_i`=1 at a load: sample computed from phase 0, p <= `phase_inc_i`. `sync_i`=1 without load: p <= 0; held sample unchanged.
- `mode_i`, `duty_i`, `phase_inc_i` sampled only at load edges; change takes effect on that sample, no glitch on held data.
- Emitted sequence (ready high, no sync): wave(0), wave(inc), wave(2·inc), …
- Waveforms, A = 2^(width_p-1)-1, msb = p[P-1]:
  - Sawtooth: t = p[P-1 -: width_p]; data = t with MSB inverted (t − 2^(width_p-1)). Range −2^(width_p-1) … +2^(width_p-1)−1.
  - Triangle: u = p[P-2 -: width_p]; v = msb ? ~u : u; data = v with MSB inverted.
  - Square: msb=0 → +A, else −A.
  - Pulse: p[P-1 -: 8] < `duty_i` → +A, else −A. Duty 0 → always −A.
- `phase_inc_i`=0: constant output equal to wave(current p).
- All arithmetic unsigned modulo 2^P on phase; no saturation anywhere.

## Timing
- Reset (sync, active-high): p=0, `valid_o`=0, `data_o`=0 on the edge where `reset_i`=1; held while asserted. Reset overrides sync and handshake.
- First edge with `reset_i`=0: load wave(0); `valid_o`=1 from the following cycle. Latency reset-release → first valid: 1 cycle.
- Throughput: one sample per cycle with `ready_i` held high.
- `valid_o` never drops once high except by reset; `data_o` stable while `valid_o`=1 and `ready_i`=0.
- `ready_i` may toggle freely, including while `valid_o`=0 (ignored then).
- Reset mid-stream: next cycle `valid_o`=0, `data_o`=0; after release sequence restarts at wave(0).
- No combinational path from inputs to outputs.

## Test plan
(width_p=12, phase_width_p=24, inc=262144 → 64 samples/period, `ready_i`=1)
- Triangle: samples k=0,16,31,32,33,63 → −2048, 0, 1920, 2047, 1919, −1921; period repeats at k=64.
- Sawtooth: k=0,32,63,64 → −2048, 0, 1984, −2048 (phase wrap).
- Square and pulse: square k=0..31 → +2047, k=32..63 → −2047; pulse `duty_i`=64 → +2047 for k=0..15, −2047 for k=16..63; `duty_i`=0 → all −2047.
- Backpressure: saw running, drop `ready_i` for 5 cycles at k=10 → `data_o`=−1408 and `valid_o`=1 held 5 cycles; on resume next sample is k=11 (−1344), no sample skipped or duplicated.
- Sync and mode change: assert `sync_i` at load of k=20 → that sample is wave(0), next is wave(inc); switch `mode_i` 1→2 with `ready_i` low → held sample unchanged, new mode appears on next accepted sample.
- Reset: assert `reset_i` mid-stream for 1 cycle → `valid_o`=0, `data_o`=0 next cycle; after release first sample −2048 (saw) one cycle later; `phase_inc_i`=0 → constant −2048.
